// File: rtl/wait_gen.sv
// rtl/wait_gen.sv - wait-state generator stretching 6809-style bus cycles for slow peripherals
module wait_gen #(
    parameter int WAIT0 = 0,
    parameter int WAIT1 = 24,
    parameter int WAIT2 = 48,
    parameter int WAIT3 = 96,
    parameter int CW    = 8
) (
    input  logic       MHZ48,
    input  logic       nRESET,
    input  logic       nQ,
    input  logic       nE,
    input  logic       nSEL,
    input  logic [1:0] WAITSEL,
    output logic       nWAIT,
    output logic       ACTIVE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          nwait_n, active_n;
    logic          nq_d, ne_d;
    logic          qrise, efall;
    logic [CW-1:0] wait_len;

    assign qrise = nq_d & ~nQ;
    assign efall = ~ne_d & nE;

    always_comb begin
        wait_len = '0;
        case (WAITSEL)
            2'd0:    wait_len = CW'(WAIT0);
            2'd1:    wait_len = CW'(WAIT1);
            2'd2:    wait_len = CW'(WAIT2);
            default: wait_len = CW'(WAIT3);
        endcase
    end

    // Length is latched at the qrise tick; WAITSEL/nSEL are don't-care afterwards.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        nwait_n  = nWAIT;
        active_n = ACTIVE;
        case (state)
            ST_IDLE: begin
                if (qrise && !nSEL) begin
                    if (wait_len != '0) begin
                        state_n  = ST_WAIT;
                        cnt_n    = wait_len - CW'(1);
                        nwait_n  = 1'b0;
                        active_n = 1'b1;
                    end else begin
                        state_n = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_n  = ST_HOLD;
                    nwait_n  = 1'b1;
                    active_n = 1'b0;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                // Only the end of E re-arms, so one stretch per bus cycle.
                if (efall) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                nwait_n  = 1'b1;
                active_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge MHZ48) begin
        if (!nRESET) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            nWAIT  <= 1'b1;
            ACTIVE <= 1'b0;
            nq_d   <= 1'b1;
            ne_d   <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            nWAIT  <= nwait_n;
            ACTIVE <= active_n;
            nq_d   <= nQ;
            ne_d   <= nE;
        end
    end

endmodule

// File: tb/tb_wait_gen.sv
// tb/tb_wait_gen.sv - scoreboard bench for wait_gen
module tb_wait_gen;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       nq = 1'b1;
    logic       ne = 1'b0;
    logic       nsel = 1'b1;
    logic [1:0] waitsel = 2'd0;
    logic       nwait, active;

    int checks = 0;
    int failures = 0;
    int tick = 0;

    typedef struct {
        int start;
        int width;
    } pulse_t;

    pulse_t exp_q[$];

    wait_gen dut (
        .MHZ48   (clk),
        .nRESET  (nreset),
        .nQ      (nq),
        .nE      (ne),
        .nSEL    (nsel),
        .WAITSEL (waitsel),
        .nWAIT   (nwait),
        .ACTIVE  (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // Monitor: every completed nWAIT pulse is matched against the expected queue.
    logic in_pulse = 1'b0;
    logic unexp = 1'b0;
    int   start_t = 0;

    always @(negedge clk) begin
        checks++;
        if (active !== ~nwait) begin
            failures++;
            $display("FAIL active_vs_nwait tick=%0d ACTIVE=%b nWAIT=%b", tick, active, nwait);
        end
        if (!in_pulse && nwait === 1'b0) begin
            in_pulse = 1'b1;
            start_t  = tick;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                unexp = 1'b1;
                $display("FAIL unexpected_pulse start=%0d expected no pulse", tick);
            end else if (exp_q[0].start != tick) begin
                failures++;
                $display("FAIL pulse_start got=%0d expected=%0d", tick, exp_q[0].start);
            end
        end else if (in_pulse && nwait === 1'b1) begin
            pulse_t e;
            in_pulse = 1'b0;
            if (!unexp) begin
                checks++;
                e = exp_q.pop_front();
                if (tick - start_t != e.width) begin
                    failures++;
                    $display("FAIL pulse_width start=%0d got=%0d expected=%0d",
                             start_t, tick - start_t, e.width);
                end
            end
            unexp = 1'b0;
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_out(input string name);
        checks++;
        if (nwait !== 1'b1 || active !== 1'b0) begin
            failures++;
            $display("FAIL %s nWAIT=%b ACTIVE=%b expected nWAIT=1 ACTIVE=0", name, nwait, active);
        end
    endtask

    // nQ falls just after edge p; qrise is seen at p+1, so the pulse starts there.
    task automatic qfall(input logic sel, input logic [1:0] ws, input int n);
        pulse_t e;
        nq = 1'b0;
        nsel = sel;
        waitsel = ws;
        if (n > 0) begin
            e.start = tick + 1;
            e.width = n;
            exp_q.push_back(e);
        end
    endtask

    task automatic efall_pulse();
        ne = 1'b1;
        ticks(1);
        ne = 1'b0;
        ticks(1);
    endtask

    task automatic bus_cycle(input logic sel, input logic [1:0] ws, input int n);
        qfall(sel, ws, n);
        ticks(n + 4);
        nq = 1'b1;
        ticks(2);
        efall_pulse();
        ticks(2);
    endtask

    initial begin
        // Reset with phases toggling
        nreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ticks(1);
            nq = ~nq;
            ne = ~ne;
            check_idle_out("reset_hold");
        end
        nq = 1'b1;
        ne = 1'b0;
        ticks(1);
        nreset = 1'b1;
        ticks(1);
        check_idle_out("after_release");
        ticks(3);

        // WAITSEL=2: 48-tick pulse, no retrigger in HOLD
        qfall(1'b0, 2'd2, 48);
        ticks(52);
        nq = 1'b1;
        ticks(1);
        nq = 1'b0;
        ticks(1);
        nq = 1'b1;
        ticks(2);
        check_idle_out("hold_no_retrigger");
        efall_pulse();
        ticks(2);

        // WAITSEL=0: no stretch, back to IDLE at nE rise
        bus_cycle(1'b0, 2'd0, 0);

        // nSEL high at qrise, low later: no wait; then WAITSEL=1 gives 24
        qfall(1'b1, 2'd1, 0);
        ticks(2);
        nsel = 1'b0;
        ticks(30);
        nq = 1'b1;
        ticks(2);
        efall_pulse();
        ticks(2);
        bus_cycle(1'b0, 2'd1, 24);

        // WAITSEL=3 with WAITSEL/nSEL changing mid-pulse
        qfall(1'b0, 2'd3, 96);
        ticks(5);
        waitsel = 2'd1;
        nsel = 1'b1;
        ticks(95);
        nq = 1'b1;
        ticks(2);
        efall_pulse();
        ticks(2);

        // Simultaneous qrise and efall in HOLD: efall wins, qrise ignored
        qfall(1'b0, 2'd1, 24);
        ticks(28);
        nq = 1'b1;
        ticks(1);
        nq = 1'b0;
        ne = 1'b1;
        ticks(1);
        ne = 1'b0;
        ticks(5);
        check_idle_out("simul_no_trigger");
        nq = 1'b1;
        ticks(1);
        bus_cycle(1'b0, 2'd1, 24);

        // Reset 20 ticks into a 48-tick pulse
        qfall(1'b0, 2'd2, 20);
        ticks(20);
        nreset = 1'b0;
        nq = 1'b1;
        ticks(1);
        check_idle_out("reset_mid_wait");
        ticks(1);
        nreset = 1'b1;
        ticks(2);
        bus_cycle(1'b0, 2'd2, 48);

        // Drain: every expected pulse must have completed
        for (int i = 0; i < 200 && (exp_q.size() != 0 || in_pulse); i++) ticks(1);
        checks++;
        if (exp_q.size() != 0 || in_pulse) begin
            failures++;
            $display("FAIL drain pending=%0d in_pulse=%b expected 0/0", exp_q.size(), in_pulse);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
